// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchronizer, debounce filter, press/release
// edge pulses and hold detection with optional auto-repeat. All outputs are registered.
module button_conditioner #(
  parameter int CLK_FREQ         = 12_000_000,
  parameter int DEBOUNCE_TIME_MS = 20,
  parameter int NUM_BUTTONS      = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int ACTIVE_LOW       = 0,
  parameter int HOLD_TIME_MS     = 1000,
  parameter int REPEAT_TIME_MS   = 200
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_BUTTONS-1:0] buttons_i,
  output logic [NUM_BUTTONS-1:0] r_level_o,
  output logic [NUM_BUTTONS-1:0] r_press_o,
  output logic [NUM_BUTTONS-1:0] r_release_o,
  output logic [NUM_BUTTONS-1:0] r_hold_o
);

  localparam int CYC_PER_MS = CLK_FREQ / 1000;
  localparam int DEB_CYC    = CYC_PER_MS * DEBOUNCE_TIME_MS;
  localparam int HOLD_CYC   = CYC_PER_MS * HOLD_TIME_MS;
  localparam int REP_CYC    = CYC_PER_MS * REPEAT_TIME_MS;

  localparam int DEB_W  = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;
  localparam int HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  // Toggle fires when the counter already holds DEB_CYC-1 mismatches, so the
  // DEB_CYC-th mismatching cycle is the one that updates the level.
  localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'((DEB_CYC > 0) ? DEB_CYC - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_TOP    = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_PRE    = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD =
      HOLD_W'((REP_CYC > 0 && REP_CYC < HOLD_CYC) ? HOLD_CYC - REP_CYC : 0);
  localparam logic REPEAT_EN = (REP_CYC > 0);
  localparam logic IDLE_RAW  = (ACTIVE_LOW != 0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      logic [DEB_W-1:0]       deb_q, deb_d;
      logic                   level_q, level_d;
      logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
      logic                   hold_evt;
      logic                   press_q, release_q, hold_q;

      assign s = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;

      always_comb begin
        deb_d   = '0;
        level_d = level_q;
        if (s != level_q) begin
          if (deb_q == DEB_LAST) begin
            level_d = s;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
      end

      // Hold counter follows the next level so it reads 1 in the press cycle.
      always_comb begin
        hold_cnt_d = '0;
        hold_evt   = 1'b0;
        if (level_d) begin
          if (hold_cnt_q == HOLD_TOP) begin
            hold_cnt_d = hold_cnt_q;
          end else if (hold_cnt_q == HOLD_PRE) begin
            hold_evt   = 1'b1;
            hold_cnt_d = REPEAT_EN ? HOLD_RELOAD : HOLD_TOP;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sync_q     <= {SYNC_STAGES{IDLE_RAW}};
          deb_q      <= '0;
          level_q    <= 1'b0;
          hold_cnt_q <= '0;
          press_q    <= 1'b0;
          release_q  <= 1'b0;
          hold_q     <= 1'b0;
        end else begin
          sync_q     <= {sync_q[SYNC_STAGES-2:0], buttons_i[gi]};
          deb_q      <= deb_d;
          level_q    <= level_d;
          hold_cnt_q <= hold_cnt_d;
          press_q    <= level_d & ~level_q;
          release_q  <= ~level_d & level_q;
          hold_q     <= hold_evt;
        end
      end

      assign r_level_o[gi]   = level_q;
      assign r_press_o[gi]   = press_q;
      assign r_release_o[gi] = release_q;
      assign r_hold_o[gi]    = hold_q;
    end
  endgenerate

endmodule
